// File: rtl/crc_frame_checker.sv
// Receive-side CRC-16 checker: recomputes the CRC of the data field bit-serially,
// then delivers data, error flag and syndrome over a valid/ready handshake.
module crc_frame_checker #(
  parameter logic [15:0] POLY  = 16'h8007,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      enc_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      data_out,
  output logic             crc_err,
  output logic [15:0]      syndrome,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q;
  logic [31:0]      shift_q, shift_d;
  logic [15:0]      rx_crc_q;
  logic [3:0]       bit_cnt_q;
  logic             in_ready_q, out_valid_q, crc_err_q;
  logic [15:0]      data_q, syndrome_q;
  logic [CNT_W-1:0] good_q, err_q;

  // One long-division step: reduce by POLY when the top bit is set, then shift.
  always_comb begin
    shift_d = shift_q;
    if (shift_q[31]) begin
      shift_d[31:16] = shift_q[31:16] ^ POLY;
    end
    shift_d = shift_d << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      rx_crc_q    <= '0;
      bit_cnt_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      data_q      <= '0;
      syndrome_q  <= '0;
      good_q      <= '0;
      err_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            shift_q    <= {enc_in[31:16], 16'h0000};
            rx_crc_q   <= enc_in[15:0];
            data_q     <= enc_in[31:16];
            bit_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          shift_q   <= shift_d;
          bit_cnt_q <= bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            crc_err_q   <= (shift_d[31:16] != rx_crc_q);
            syndrome_q  <= shift_d[31:16] ^ rx_crc_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      // Clear takes precedence over a delivery on the same edge.
      if (clr_cnt) begin
        good_q <= '0;
        err_q  <= '0;
      end else if (out_valid_q && out_ready) begin
        if (crc_err_q) begin
          if (err_q != '1) begin
            err_q <= err_q + CNT_ONE;
          end
        end else begin
          if (good_q != '1) begin
            good_q <= good_q + CNT_ONE;
          end
        end
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_q;
  assign crc_err   = crc_err_q;
  assign syndrome  = syndrome_q;
  assign good_cnt  = good_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_crc_frame_checker.sv
// Scoreboard bench for crc_frame_checker: default-width instance plus a CNT_W=2
// instance sharing the same stimulus for counter saturation.
module tb_crc_frame_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] enc_in = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        clr_cnt = 1'b0;

  logic        in_ready, crc_err, out_valid;
  logic [15:0] data_out, syndrome;
  logic [15:0] good_cnt, err_cnt;

  logic        in_ready2, crc_err2, out_valid2;
  logic [15:0] data_out2, syndrome2;
  logic [1:0]  good_cnt2, err_cnt2;

  crc_frame_checker #(.POLY(16'h8007), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .enc_in(enc_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .crc_err(crc_err), .syndrome(syndrome), .out_valid(out_valid),
    .out_ready(out_ready), .clr_cnt(clr_cnt), .good_cnt(good_cnt), .err_cnt(err_cnt)
  );

  crc_frame_checker #(.POLY(16'h8007), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .enc_in(enc_in), .in_valid(in_valid), .in_ready(in_ready2),
    .data_out(data_out2), .crc_err(crc_err2), .syndrome(syndrome2), .out_valid(out_valid2),
    .out_ready(out_ready), .clr_cnt(clr_cnt), .good_cnt(good_cnt2), .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic        err;
    logic [15:0] syn;
    int          t;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [15:0] eg = '0, ee = '0;
  logic [1:0]  eg2 = '0, ee2 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: counters every cycle, result fields on each presented output.
  always @(negedge clk) begin
    if (rst) begin
      have_cur = 1'b0;
      eg = '0; ee = '0; eg2 = '0; ee2 = '0;
    end else begin
      chk("good_cnt", good_cnt, eg);
      chk("err_cnt", err_cnt, ee);
      chk("good_cnt_w2", good_cnt2, eg2);
      chk("err_cnt_w2", err_cnt2, ee2);
      if (out_valid) begin
        if (!have_cur) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out_valid: got out_valid=1 expected no pending frame (cycle %0d)", cyc);
          end else begin
            cur = sb.pop_front();
            have_cur = 1'b1;
            chk("latency", cyc, cur.t + 16);
          end
        end
        if (have_cur) begin
          chk("data_out", data_out, cur.data);
          chk("crc_err", crc_err, cur.err);
          chk("syndrome", syndrome, cur.syn);
          chk("in_ready_in_done", in_ready, 0);
          if (out_ready) begin
            if (!clr_cnt) begin
              if (cur.err) begin
                if (ee != 16'hFFFF) ee = ee + 16'd1;
                if (ee2 != 2'd3) ee2 = ee2 + 2'd1;
              end else begin
                if (eg != 16'hFFFF) eg = eg + 16'd1;
                if (eg2 != 2'd3) eg2 = eg2 + 2'd1;
              end
            end
            have_cur = 1'b0;
          end
        end
      end
      if (clr_cnt) begin
        eg = '0; ee = '0; eg2 = '0; ee2 = '0;
      end
    end
  end

  task automatic send(input logic [31:0] w, input logic err_exp, input logic [15:0] syn_exp,
                      output int t_acc);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    t_acc = 0;
    @(posedge clk); #1;
    enc_in = w;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.data = w[31:16];
        e.err  = err_exp;
        e.syn  = syn_exp;
        e.t    = cyc + 1;
        t_acc  = cyc + 1;
        sb.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 60 cycles for %h", w);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    enc_in = $urandom;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !have_cur && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic wait_out_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL out_valid_timeout: got out_valid=0 expected 1 within 40 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_crc_err", crc_err, 0);
    chk("rst_syndrome", syndrome, 0);

    // Directed vectors, CRCs worked by hand for POLY 8007.
    send(32'h0000_0000, 1'b0, 16'h0000, t);
    send(32'h0001_000E, 1'b0, 16'h0000, t);
    send(32'h8000_002A, 1'b0, 16'h0000, t);
    send(32'h0001_000F, 1'b1, 16'h0001, t);
    send(32'h0003_000E, 1'b1, 16'h001C, t);
    send(32'h0003_0012, 1'b0, 16'h0000, t);
    wait_idle();
    chk("good_after_vectors", good_cnt, 4);
    chk("err_after_vectors", err_cnt, 2);

    // Back-pressure: result held, no new word accepted.
    @(posedge clk); #1 out_ready = 1'b0;
    send(32'h0001_000E, 1'b0, 16'h0000, t);
    wait_out_valid();
    @(posedge clk); #1;
    in_valid = 1'b1;
    enc_in = 32'h1234_5678;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_data_out", data_out, 16'h0001);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
    repeat (20) @(negedge clk);
    chk("held_word_not_taken", out_valid, 0);

    // Reset mid-CALC discards the frame.
    send(32'h0001_000E, 1'b0, 16'h0000, t);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_good", good_cnt, 0);
    chk("midrst_err", err_cnt, 0);
    repeat (25) @(negedge clk);
    chk("midrst_no_delivery", out_valid, 0);
    send(32'h0001_000E, 1'b0, 16'h0000, t);
    wait_idle();
    chk("post_rst_good", good_cnt, 1);

    // Saturation of the 2-bit counters.
    for (int i = 0; i < 5; i++) send(32'h0000_0000, 1'b0, 16'h0000, t);
    wait_idle();
    chk("sat_good_w2", good_cnt2, 3);
    chk("sat_good_w16", good_cnt, 6);

    // Clear on the same edge as a delivery.
    @(posedge clk); #1 out_ready = 1'b0;
    send(32'h0000_0000, 1'b0, 16'h0000, t);
    wait_out_valid();
    @(posedge clk); #1;
    out_ready = 1'b1;
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_good_w16", good_cnt, 0);
    chk("clr_good_w2", good_cnt2, 0);
    chk("clr_out_valid", out_valid, 0);

    wait_idle();
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
